// File: rtl/clk_div_pkg.sv
// Shared constants and types for the UART clocking blocks.
// Imported by the clock divider, its interface and its testbench.
package clk_div_pkg;

    localparam int DEFAULT_WIDTH = 8;
    // Ratios below this value bypass the divider and pass the reference clock.
    localparam int DIV_MIN       = 2;

    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } phase_e;

endpackage

// File: rtl/clk_div_if.sv
// Control/output bundle of the clock divider: enable and ratio in, divided clock out.
interface clk_div_if import clk_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             clk_en;
    logic [WIDTH-1:0] div_ratio;
    logic             div_clk;

    modport master (
        output clk_en,
        output div_ratio,
        input  div_clk
    );

    modport slave (
        input  clk_en,
        input  div_ratio,
        output div_clk
    );

endinterface

// File: rtl/clk_div_mux.sv
// 2:1 clock select between the reference clock and the divided level.
// Isolated so implementation can pin it to a dedicated clock-mux cell.
module clk_div_mux (
    input  logic clk_ref,
    input  logic clk_alt,
    input  logic sel,
    output logic clk_out
);

    assign clk_out = sel ? clk_alt : clk_ref;

endmodule

// File: rtl/clk_div.sv
// Integer clock divider: low phase = N/2 cycles, high phase = N/2 + N[0] cycles.
// Ratios below DIV_MIN or a deasserted enable pass the reference clock straight through.
module clk_div import clk_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    clk_div_if.slave   bus
);

    localparam logic [WIDTH-2:0] CNT_ZERO  = {(WIDTH-1){1'b0}};
    localparam logic [WIDTH-2:0] CNT_ONE   = {{(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RATIO_RST = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ratio_r;
    logic [WIDTH-2:0] cnt_r;
    phase_e           phase_r;

    logic             mode_s;
    logic [WIDTH-2:0] half_s;
    logic [WIDTH-2:0] lo_term_s;
    logic [WIDTH-2:0] hi_term_s;
    logic [WIDTH-2:0] cnt_inc_s;
    logic             div_level_s;

    // half-1 never underflows while dividing because ratio_r >= 2 there.
    assign mode_s      = bus.clk_en & (ratio_r >= WIDTH'(DIV_MIN));
    assign half_s      = ratio_r[WIDTH-1:1];
    assign lo_term_s   = half_s - CNT_ONE;
    assign hi_term_s   = lo_term_s + {{(WIDTH-2){1'b0}}, ratio_r[0]};
    assign cnt_inc_s   = cnt_r + CNT_ONE;
    assign div_level_s = (phase_r == PHASE_HIGH);

    // Phase counter and ratio capture; new ratios are accepted only at the high-to-low boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ratio_r <= RATIO_RST;
            cnt_r   <= CNT_ZERO;
            phase_r <= PHASE_LOW;
        end else if (!mode_s) begin
            ratio_r <= bus.div_ratio;
            cnt_r   <= CNT_ZERO;
            phase_r <= PHASE_LOW;
        end else begin
            case (phase_r)
                PHASE_LOW: begin
                    if (cnt_r == lo_term_s) begin
                        cnt_r   <= CNT_ZERO;
                        phase_r <= PHASE_HIGH;
                    end else begin
                        cnt_r   <= cnt_inc_s;
                    end
                end
                PHASE_HIGH: begin
                    if (cnt_r == hi_term_s) begin
                        cnt_r   <= CNT_ZERO;
                        phase_r <= PHASE_LOW;
                        ratio_r <= bus.div_ratio;
                    end else begin
                        cnt_r   <= cnt_inc_s;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    phase_r <= PHASE_LOW;
                end
            endcase
        end
    end

    clk_div_mux u_mux (
        .clk_ref (clk),
        .clk_alt (div_level_s),
        .sel     (mode_s),
        .clk_out (bus.div_clk)
    );

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: directed scenarios plus random traffic against
// a period-position model of the divided waveform.
module tb_clk_div;
    import clk_div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clk_div_if #(.WIDTH(DEFAULT_WIDTH)) bus ();

    clk_div #(.WIDTH(DEFAULT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: active ratio and position within the current output period.
    int m_ratio = 1;
    int m_pos   = 0;

    function automatic logic exp_level(input logic c);
        if (bus.clk_en && m_ratio >= 2)
            return (m_pos >= m_ratio / 2) ? 1'b1 : 1'b0;
        else
            return c;
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_ratio = 1;
            m_pos   = 0;
        end else if (!(bus.clk_en && m_ratio >= 2)) begin
            m_ratio = int'(bus.div_ratio);
            m_pos   = 0;
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == m_ratio) begin
                m_pos   = 0;
                m_ratio = int'(bus.div_ratio);
            end
        end
    endtask

    task automatic check(input string tag);
        logic e;
        e = exp_level(clk);
        n_checks++;
        assert (bus.div_clk === e) else begin
            n_fails++;
            $error("FAIL %s t=%0t clk=%b div_clk=%b expected=%b ratio=%0d pos=%0d",
                   tag, $time, clk, bus.div_clk, e, m_ratio, m_pos);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] nr,
                        input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            rst           = r;
            bus.clk_en    = en;
            bus.div_ratio = nr;
            @(posedge clk);
            model_edge();
            #1 check(tag);
            @(negedge clk);
            #1 check(tag);
        end
    endtask

    initial begin
        int sel;
        logic [7:0] rr;
        logic       ren;
        logic       rrst;

        bus.clk_en    = 1'b1;
        bus.div_ratio = 8'd8;

        step(1'b0, 1'b1, 8'd8, 3, "reset_bypass");
        step(1'b1, 1'b1, 8'd8, 82, "ratio8");
        step(1'b1, 1'b1, 8'd2, 12, "ratio2");
        step(1'b1, 1'b1, 8'd4, 20, "ratio4");
        step(1'b1, 1'b1, 8'd5, 25, "ratio5");
        step(1'b1, 1'b1, 8'd3, 15, "ratio3");
        step(1'b1, 1'b1, 8'd0, 12, "ratio0");
        step(1'b1, 1'b1, 8'd1, 12, "ratio1");

        // Ratio 8 -> 2 requested on the third cycle of a high phase.
        for (int i = 0; i < 30 && !(m_ratio == 8 && m_pos == 6); i++)
            step(1'b1, 1'b1, 8'd8, 1, "r8_pre");
        step(1'b1, 1'b1, 8'd2, 20, "r8_to_r2");

        // Enable dropped for 3 cycles in the middle of a low phase.
        for (int i = 0; i < 30 && !(m_ratio == 4 && m_pos == 1); i++)
            step(1'b1, 1'b1, 8'd4, 1, "r4_pre");
        step(1'b1, 1'b0, 8'd4, 3, "en_drop");
        step(1'b1, 1'b1, 8'd4, 12, "en_resume");

        // One-cycle reset in the middle of a high phase.
        for (int i = 0; i < 30 && !(m_ratio == 8 && m_pos == 5); i++)
            step(1'b1, 1'b1, 8'd8, 1, "r8_pre_rst");
        step(1'b0, 1'b1, 8'd8, 1, "mid_reset");
        step(1'b1, 1'b1, 8'd8, 20, "after_reset");

        // Random traffic: mostly small ratios, occasional bypass, enable drops and resets.
        rr = 8'd3;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 15)
                rr = 8'($urandom_range(2, 9));
            else if (sel < 18)
                rr = 8'($urandom_range(0, 1));
            else if (sel < 19)
                rr = 8'($urandom_range(10, 255));
            ren  = ($urandom_range(0, 24) != 0);
            rrst = ($urandom_range(0, 79) != 0);
            step(rrst, ren, rr, 1, "random");
        end

        step(1'b1, 1'b1, 8'd255, 260, "ratio255");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
